// File: rtl/bundle_pkg.sv
// Shared definitions for bundle decode: unit codes, template table, slot field ranges, decode bus layout.
package bundle_pkg;

  typedef enum logic [2:0] {
    NUnit = 3'd0,
    BUnit = 3'd1,
    IUnit = 3'd2,
    FUnit = 3'd3,
    MUnit = 3'd4
  } unit_e;

  localparam int SLOT_W     = 40;
  localparam int SLOT0_LSB  = 0;
  localparam int SLOT1_LSB  = 40;
  localparam int SLOT2_LSB  = 80;
  localparam int TMPL_LSB   = 120;
  localparam int TMPL_W     = 8;
  localparam int TMPL_ENT_W = 10;
  localparam int TMPL_NUM   = 128;

  typedef struct packed {
    logic [3:0] opc;
    logic [7:0] imm;
    logic [5:0] rb;
    logic [5:0] ra;
    logic [5:0] rt;
    logic [3:0] ext;
    logic [5:0] qp;
    logic       br;
    logic       mem;
    logic       fp;
    logic       alu;
    logic       wr_rt;
    logic       dbg;
  } dec_t;

  localparam int IBTOP = $bits(dec_t) - 1;

  typedef struct packed {
    logic       ill;
    logic [2:0] u2;
    logic [2:0] u1;
    logic [2:0] u0;
  } tmpl_ent_t;

  // Template index is a base-5 number u0 + 5*u1 + 25*u2; codes 125..127 are unassigned.
  function automatic logic [TMPL_NUM*TMPL_ENT_W-1:0] gen_tmpl_table();
    logic [TMPL_NUM*TMPL_ENT_W-1:0] t;
    t = '0;
    for (int i = 0; i < TMPL_NUM; i++) begin
      if (i >= 125) t[i*TMPL_ENT_W +: TMPL_ENT_W] = 10'h200;
      else          t[i*TMPL_ENT_W +: TMPL_ENT_W] = {1'b0, 3'(i / 25), 3'((i / 5) % 5), 3'(i % 5)};
    end
    return t;
  endfunction

  localparam logic [TMPL_NUM*TMPL_ENT_W-1:0] TMPL_TABLE = gen_tmpl_table();

  // Template byte values with the top bit set fall outside the table and are illegal.
  function automatic tmpl_ent_t tmpl_lookup(input logic [TMPL_W-1:0] tmpl);
    tmpl_ent_t e;
    e = tmpl_ent_t'(TMPL_TABLE[int'(tmpl[6:0])*TMPL_ENT_W +: TMPL_ENT_W]);
    if (tmpl[7]) e.ill = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/bundle_decode_sequencer_idecoder.sv
// Purpose: combinational slot decoder producing the packed decode bus.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller registers the result only when it advances.
module bundle_decode_sequencer_idecoder
  import bundle_pkg::*;
(
  input  logic [2:0]        unit,
  input  logic [SLOT_W-1:0] instr,
  input  logic              debug_on,
  output dec_t              dec
);

  always_comb begin
    dec       = '0;
    dec.opc   = instr[39:36];
    dec.imm   = instr[35:28];
    dec.rb    = instr[27:22];
    dec.ra    = instr[21:16];
    dec.rt    = instr[15:10];
    dec.ext   = instr[9:6];
    dec.qp    = instr[5:0];
    dec.br    = (unit == BUnit);
    dec.mem   = (unit == MUnit);
    dec.fp    = (unit == FUnit);
    dec.alu   = (unit == IUnit);
    // Branches and NOPs never write a general register, and r0 is not a real target.
    dec.wr_rt = (instr[15:10] != 6'd0) && (unit != BUnit) && (unit != NUnit);
    dec.dbg   = debug_on;
  end

endmodule

// File: rtl/bundle_decode_sequencer.sv
// Purpose: holds one instruction bundle and issues its live slots one per cycle through a shared decoder.
// Latency: first slot presented one cycle after bundle accept; sustained 1 slot/cycle.
// Backpressure: out_ready_i low freezes the output register and the pending mask; in_ready_o drops while more than one slot remains.
module bundle_decode_sequencer
  import bundle_pkg::*;
#(
  parameter int AMSB     = 63,
  parameter bit SKIP_NOP = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [127:0]      in_bundle_i,
  input  logic [AMSB:0]     in_pc_i,
  input  logic [1:0]        in_pt_slot_i,
  input  logic              debug_on_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [IBTOP:0]    out_bus_o,
  output logic [SLOT_W-1:0] out_instr_o,
  output logic [2:0]        out_unit_o,
  output logic [AMSB:0]     out_pc_o,
  output logic              out_pt_o,
  output logic              out_last_o,
  output logic              ill_tmpl_o
);

  localparam int AW = AMSB + 1;

  typedef enum logic {EMPTY = 1'b0, ISSUE = 1'b1} state_e;

  state_e              state;
  logic [3*SLOT_W-1:0] hold_slots;
  logic [8:0]          hold_units;
  logic [AMSB:0]       hold_pc;
  logic [1:0]          hold_pt;
  logic [2:0]          mask;

  logic                hold_v;
  logic                adv;
  logic                mask_one;
  logic                accept;
  tmpl_ent_t           in_ent;
  logic [2:0]          in_live;
  logic [2:0]          in_keep;
  logic [2:0]          in_mask;
  logic [1:0]          sel_idx;
  logic [2:0]          sel_bit;
  logic [SLOT_W-1:0]   sel_slot;
  logic [2:0]          sel_unit;
  dec_t                dec;

  assign hold_v     = (state == ISSUE);
  assign adv        = ~out_valid_o | out_ready_i;
  assign mask_one   = $onehot(mask);
  assign in_ready_o = ~flush_i & (~hold_v | (adv & mask_one));
  assign accept     = in_valid_i & in_ready_o;

  // Slots after the predicted-taken one are dead on arrival, so they never enter the mask.
  always_comb begin
    in_ent  = tmpl_lookup(in_bundle_i[TMPL_LSB +: TMPL_W]);
    in_live = SKIP_NOP ? {in_ent.u2 != NUnit, in_ent.u1 != NUnit, in_ent.u0 != NUnit} : 3'b111;
    case (in_pt_slot_i)
      2'd0:    in_keep = 3'b001;
      2'd1:    in_keep = 3'b011;
      default: in_keep = 3'b111;
    endcase
    in_mask = in_ent.ill ? 3'b000 : (in_live & in_keep);
  end

  always_comb begin
    sel_idx = 2'd0;
    sel_bit = 3'b001;
    if (mask[0]) begin
      sel_idx = 2'd0;
      sel_bit = 3'b001;
    end else if (mask[1]) begin
      sel_idx = 2'd1;
      sel_bit = 3'b010;
    end else if (mask[2]) begin
      sel_idx = 2'd2;
      sel_bit = 3'b100;
    end
    sel_slot = hold_slots[sel_idx*SLOT_W +: SLOT_W];
    sel_unit = hold_units[sel_idx*3 +: 3];
  end

  bundle_decode_sequencer_idecoder u_idecoder (
    .unit     (sel_unit),
    .instr    (sel_slot),
    .debug_on (debug_on_i),
    .dec      (dec)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      mask        <= '0;
      hold_slots  <= '0;
      hold_units  <= '0;
      hold_pc     <= '0;
      hold_pt     <= '0;
      out_valid_o <= 1'b0;
      out_bus_o   <= '0;
      out_instr_o <= '0;
      out_unit_o  <= '0;
      out_pc_o    <= '0;
      out_pt_o    <= 1'b0;
      out_last_o  <= 1'b0;
      ill_tmpl_o  <= 1'b0;
    end else if (flush_i) begin
      state       <= EMPTY;
      mask        <= '0;
      out_valid_o <= 1'b0;
      ill_tmpl_o  <= 1'b0;
    end else begin
      ill_tmpl_o <= accept & in_ent.ill;
      if (adv) begin
        out_valid_o <= hold_v;
        if (hold_v) begin
          out_bus_o   <= dec;
          out_instr_o <= sel_slot;
          out_unit_o  <= sel_unit;
          out_pc_o    <= hold_pc | AW'(sel_idx);
          out_pt_o    <= ({1'b0, sel_idx} == {1'b0, hold_pt});
          out_last_o  <= mask_one;
        end
      end
      // Accept only happens when the held bundle is empty or issuing its final slot.
      if (accept) begin
        hold_slots <= in_bundle_i[3*SLOT_W-1:0];
        hold_units <= {in_ent.u2, in_ent.u1, in_ent.u0};
        hold_pc    <= in_pc_i;
        hold_pt    <= in_pt_slot_i;
        mask       <= in_mask;
        state      <= (in_mask != 3'b000) ? ISSUE : EMPTY;
      end else if (hold_v && adv) begin
        mask <= mask & ~sel_bit;
        if (mask_one) state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_bundle_decode_sequencer.sv
// Directed, table-driven bench for bundle_decode_sequencer with hand-computed expectations.
module tb_bundle_decode_sequencer;

  localparam int AMSB = 63;
  localparam int BW   = bundle_pkg::IBTOP + 1;

  logic            clk_i;
  logic            rst_i;
  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [127:0]    in_bundle_i;
  logic [AMSB:0]   in_pc_i;
  logic [1:0]      in_pt_slot_i;
  logic            debug_on_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [BW-1:0]   out_bus_o;
  logic [39:0]     out_instr_o;
  logic [2:0]      out_unit_o;
  logic [AMSB:0]   out_pc_o;
  logic            out_pt_o;
  logic            out_last_o;
  logic            ill_tmpl_o;

  bundle_decode_sequencer #(.AMSB(AMSB), .SKIP_NOP(1'b1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_bundle_i  (in_bundle_i),
    .in_pc_i      (in_pc_i),
    .in_pt_slot_i (in_pt_slot_i),
    .debug_on_i   (debug_on_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_bus_o    (out_bus_o),
    .out_instr_o  (out_instr_o),
    .out_unit_o   (out_unit_o),
    .out_pc_o     (out_pc_o),
    .out_pt_o     (out_pt_o),
    .out_last_o   (out_last_o),
    .ill_tmpl_o   (ill_tmpl_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       vld;
    logic [7:0] tmpl;
    logic [1:0] pt;
    logic       ordy;
    logic       fl;
    logic       dbg;
    logic       e_rdy;
    logic       e_ov;
    logic [7:0] e_tmpl;
    logic [1:0] e_off;
    logic [2:0] e_unit;
    logic       e_last;
    logic       e_pt;
    logic       e_dbg;
    logic       e_ill;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [39:0] slot_of(input logic [7:0] t, input int s);
    logic [39:0] w;
    w = {4'(s + 5), t, 6'(s + 1), t[5:0], 6'(s * 9 + 2), 4'hA, t[5:0] ^ 6'(s)};
    return w;
  endfunction

  function automatic logic [127:0] bundle_of(input logic [7:0] t);
    return {t, slot_of(t, 2), slot_of(t, 1), slot_of(t, 0)};
  endfunction

  function automatic logic [63:0] pc_of(input logic [7:0] t);
    return 64'h0000_0000_8000_0000 | {52'd0, t, 4'h0};
  endfunction

  // Expected decode bus: raw slot fields in order, then br/mem/fp/alu/wr_rt/dbg flags.
  function automatic logic [BW-1:0] bus_of(input logic [39:0] ins, input logic [2:0] u, input logic d);
    logic wr;
    wr = (ins[15:10] != 6'd0) && (u != 3'd1) && (u != 3'd0);
    return {ins, u == 3'd1, u == 3'd4, u == 3'd3, u == 3'd2, wr, d};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic row(input logic vld, input logic [7:0] tmpl, input logic [1:0] pt,
                     input logic ordy, input logic fl, input logic dbg,
                     input logic e_rdy, input logic e_ov, input logic [7:0] e_tmpl,
                     input logic [1:0] e_off, input logic [2:0] e_unit, input logic e_last,
                     input logic e_pt, input logic e_dbg, input logic e_ill);
    vec_t v;
    v.vld = vld;   v.tmpl = tmpl;   v.pt = pt;       v.ordy = ordy;   v.fl = fl;
    v.dbg = dbg;   v.e_rdy = e_rdy; v.e_ov = e_ov;   v.e_tmpl = e_tmpl;
    v.e_off = e_off; v.e_unit = e_unit; v.e_last = e_last; v.e_pt = e_pt;
    v.e_dbg = e_dbg; v.e_ill = e_ill;
    vt.push_back(v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, 128'(out_valid_o), 128'd0);
    chk({tag, " out_bus"},   128'(out_bus_o),   128'd0);
    chk({tag, " out_instr"}, 128'(out_instr_o), 128'd0);
    chk({tag, " out_unit"},  128'(out_unit_o),  128'd0);
    chk({tag, " out_pc"},    128'(out_pc_o),    128'd0);
    chk({tag, " out_pt"},    128'(out_pt_o),    128'd0);
    chk({tag, " out_last"},  128'(out_last_o),  128'd0);
    chk({tag, " ill_tmpl"},  128'(ill_tmpl_o),  128'd0);
  endtask

  initial begin
    vec_t        v;
    logic [39:0] ins;

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_bundle_i = '0; in_pc_i = '0;
    in_pt_slot_i = 2'd3; debug_on_i = 1'b0; out_ready_i = 1'b1;

    // Templates: 47={I,M,B}, 77={I,N,F}, 61={B,I,I}, 0=all NOP, 125/128 illegal.
    row(1, 47, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0);
    row(0,  0, 3, 1, 0, 1,  0, 1, 47, 0, 2, 0, 0, 1, 0);
    row(0,  0, 3, 1, 0, 0,  0, 1, 47, 1, 4, 0, 0, 0, 0);
    row(1, 77, 3, 1, 0, 1,  1, 1, 47, 2, 1, 1, 0, 1, 0);
    row(0,  0, 3, 1, 0, 0,  0, 1, 77, 0, 2, 0, 0, 0, 0);
    row(1, 61, 0, 1, 0, 1,  1, 1, 77, 2, 3, 1, 0, 1, 0);
    row(0,  0, 3, 1, 0, 0,  1, 1, 61, 0, 1, 1, 1, 0, 0);
    row(1,  0, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0);
    row(1,125, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 1);
    row(1,128, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 1);
    row(0,  0, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0);
    // Backpressure: four stalled cycles hold slot0, then the rest stream out.
    row(1, 47, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0);
    row(0,  0, 3, 0, 0, 0,  0, 1, 47, 0, 2, 0, 0, 0, 0);
    row(1, 77, 3, 0, 0, 1,  0, 1, 47, 0, 2, 0, 0, 0, 0);
    row(0,  0, 3, 0, 0, 1,  0, 1, 47, 0, 2, 0, 0, 0, 0);
    row(0,  0, 3, 0, 0, 1,  0, 1, 47, 0, 2, 0, 0, 0, 0);
    row(0,  0, 3, 0, 0, 1,  0, 1, 47, 0, 2, 0, 0, 0, 0);
    row(0,  0, 3, 1, 0, 1,  0, 1, 47, 1, 4, 0, 0, 1, 0);
    row(0,  0, 3, 1, 0, 0,  1, 1, 47, 2, 1, 1, 0, 0, 0);
    row(0,  0, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0);
    // Flush while slot1 is presented; bundle offered in the flush cycle is refused.
    row(1, 47, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0);
    row(0,  0, 3, 1, 0, 1,  0, 1, 47, 0, 2, 0, 0, 1, 0);
    row(0,  0, 3, 1, 0, 0,  0, 1, 47, 1, 4, 0, 0, 0, 0);
    row(1, 77, 3, 1, 1, 0,  0, 0,  0, 0, 0, 0, 0, 0, 0);
    row(0,  0, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0);
    row(0,  0, 3, 1, 0, 0,  1, 0,  0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    chk_zero("reset");
    chk("reset in_ready", 128'(in_ready_o), 128'd1);

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      in_valid_i   = v.vld;
      in_bundle_i  = bundle_of(v.tmpl);
      in_pc_i      = pc_of(v.tmpl);
      in_pt_slot_i = v.pt;
      out_ready_i  = v.ordy;
      flush_i      = v.fl;
      debug_on_i   = v.dbg;
      #1;
      chk($sformatf("row%0d in_ready", i), 128'(in_ready_o), 128'(v.e_rdy));
      @(posedge clk_i);
      #1;
      chk($sformatf("row%0d out_valid", i), 128'(out_valid_o), 128'(v.e_ov));
      chk($sformatf("row%0d ill_tmpl", i),  128'(ill_tmpl_o),  128'(v.e_ill));
      if (v.e_ov) begin
        ins = slot_of(v.e_tmpl, int'(v.e_off));
        chk($sformatf("row%0d out_unit", i),  128'(out_unit_o),  128'(v.e_unit));
        chk($sformatf("row%0d out_pc", i),    128'(out_pc_o),    128'(pc_of(v.e_tmpl) | 64'(v.e_off)));
        chk($sformatf("row%0d out_last", i),  128'(out_last_o),  128'(v.e_last));
        chk($sformatf("row%0d out_pt", i),    128'(out_pt_o),    128'(v.e_pt));
        chk($sformatf("row%0d out_instr", i), 128'(out_instr_o), 128'(ins));
        chk($sformatf("row%0d out_bus", i),   128'(out_bus_o),   128'(bus_of(ins, v.e_unit, v.e_dbg)));
      end
    end

    // Reset in the middle of a bundle discards it and zeroes every output.
    flush_i = 1'b0; out_ready_i = 1'b1; debug_on_i = 1'b1;
    in_valid_i = 1'b1; in_bundle_i = bundle_of(8'd47); in_pc_i = pc_of(8'd47); in_pt_slot_i = 2'd3;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("midrst pre out_valid", 128'(out_valid_o), 128'd1);
    chk("midrst pre out_unit",  128'(out_unit_o),  128'd2);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk_zero("midrst");
    rst_i = 1'b0;
    chk("midrst in_ready", 128'(in_ready_o), 128'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("midrst drain%0d out_valid", k), 128'(out_valid_o), 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bundle_decode_sequencer.md
Name: bundle_decode_sequencer

Overview:
- Sits between the instruction fetch buffer and the re-order-queue enqueue logic.
- Accepts 128-bit instruction bundles (three 40-bit slots plus a template) and decodes the template into per-slot unit codes.
- Feeds one non-NOP slot per cycle through a single shared idecoder instance and presents the registered decode bus downstream with a valid/ready handshake.
- Handles predicted-taken truncation of a bundle and pipeline flush.

Parameters:
- AMSB, 63, MSB of instruction addresses.
- SKIP_NOP, 1, when 1 slots whose template unit is NUnit (3'd0) are not issued.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  discard held bundle and output register
- in_valid_i  in  1  bundle offered
- in_ready_o  out  1  bundle accepted when in_valid_i & in_ready_o
- in_bundle_i  in  128  slot0=[39:0], slot1=[79:40], slot2=[119:80], template=[127:120]
- in_pc_i  in  AMSB+1  bundle address (low 4 bits zero)
- in_pt_slot_i  in  2  slot predicted taken by fetch; 3 = none
- debug_on_i  in  1  forwarded to decoder
- out_valid_o  out  1  decoded slot available
- out_ready_i  in  1  downstream consumes when out_valid_o & out_ready_i
- out_bus_o  out  IBTOP+1  registered decode bus
- out_instr_o  out  40  raw slot
- out_unit_o  out  3  slot unit
- out_pc_o  out  AMSB+1  in_pc | slot index
- out_pt_o  out  1  slot carries the taken prediction
- out_last_o  out  1  final issued slot of its bundle
- ill_tmpl_o  out  1  one-cycle pulse: template invalid, bundle dropped

Behaviour:
- Reset (rst_i sampled high at a clock edge): hold_v=0, slot index=0, out_valid_o=0, out_bus_o=0, out_instr_o=0, out_unit_o=0, out_pc_o=0, out_pt_o=0, out_last_o=0, ill_tmpl_o=0. Reset mid-bundle discards the bundle. in_ready_o is 1 in the first cycle after reset.
- Holding register: one bundle plus a 3-bit pending mask. On accept, the mask is computed from the template:
  - Bit s is set when the unit of slot s is not NUnit (SKIP_NOP=1), or always set (SKIP_NOP=0).
  - Bits above in_pt_slot_i are cleared, because slots after a predicted-taken slot are never issued.
- FSM states:
  - EMPTY: hold_v=0.
  - ISSUE: hold_v=1; the selected slot is the lowest set mask bit.
- Advance condition: adv = ~out_valid_o | out_ready_i.
- In ISSUE with adv:
  - The selected slot's unit/instr drive the combinational idecoder (Rt = slot[15:10]).
  - The result is registered into out_* and out_valid_o=1 on the next edge; the mask bit is cleared.
  - out_last_o=1 when no other mask bit remains set; the FSM then goes to EMPTY unless a new bundle is accepted in the same cycle.
- With adv=0 and out_valid_o=1, all out_* registers hold stable.
- In ISSUE with adv=0, the selected slot is not issued and its mask bit stays set.
- in_ready_o = ~hold_v | (adv & exactly one mask bit set). This allows back-to-back bundles with no bubble.
- Latency: a bundle accepted at edge N presents its first slot at edge N+1. Sustained throughput is 1 slot/cycle.
- Mask all-zero at accept (all-NOP bundle): no slot is issued, hold_v stays 0, and no output is produced.
- Invalid template (entry flagged illegal in the package table):
  - The bundle is accepted and dropped, and ill_tmpl_o pulses on the next cycle.
  - The address is not reported; the fetch unit raises the exception.
- flush_i (priority over everything except reset):
  - Next edge: hold_v=0, out_valid_o=0, mask=0.
  - in_ready_o is forced 0 in the flush cycle, so no bundle is accepted.
  - A flush in the same cycle as an out_ready_i handshake still counts that handshake as consumed.
- Rule: out_pt_o=1 only on the slot whose index equals in_pt_slot_i, and that slot always has out_last_o=1.

Decomposition:
- Shared package bundle_pkg holds:
  - unit codes NUnit=0, BUnit=1, IUnit=2, FUnit=3, MUnit=4;
  - the 128-entry template table (three 3-bit units plus an illegal bit);
  - slot and template field ranges;
  - the IBTOP width constant.
- The idecoder is the single instantiated sub-module.
- Template lookup and lowest-set-bit select stay inline.

Test Plan:
- Template with units {I,M,B}, in_pt_slot_i=3, out_ready_i=1:
  - Expect three outputs on consecutive cycles: pc offsets 0,1,2; units 2,4,1; out_last_o only on the third.
  - in_ready_o=1 during the third cycle, so a second bundle produces its slot0 on the next cycle.
- Template {I,N,F} with SKIP_NOP=1: expect two outputs, units 2 then 3, pc offsets 0 and 2; out_last_o on the second.
- in_pt_slot_i=0 on a {B,I,I} bundle: expect exactly one output with unit 1, out_pt_o=1 and out_last_o=1; slots 1 and 2 are never issued.
- Hold out_ready_i=0 for 4 cycles after the first output: out_bus_o, out_pc_o and out_valid_o stay stable and in_ready_o=0. Release it: the remaining slots follow on consecutive cycles.
- Assert flush_i while slot1 is presented: next cycle out_valid_o=0 and in_ready_o=1, and slot2 never appears. A bundle offered during the flush cycle is not accepted.
- Illegal template: ill_tmpl_o pulses once, no out_valid_o, in_ready_o=1 afterwards. Asserting rst_i mid-bundle clears all outputs to 0 on the next edge.
